// File: rtl/adc_stream_fifo_mc.sv
// Channel-tagged synchronous sample FIFO with a per-channel enable mask, selectable
// drop-new/drop-oldest overflow handling, an overrun counter, a watermark flag and a peak tracker.
module adc_stream_fifo_mc #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int N_CH        = 4,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LVL_W = $clog2(DEPTH_WORDS + 1),
  localparam int AW    = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  input  logic [CH_W-1:0]   push_ch,
  output logic              push_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic [CH_W-1:0]   pop_ch,
  input  logic              pop_ready,
  input  logic [N_CH-1:0]   ch_enable,
  input  logic              drop_oldest,
  input  logic              flush,
  input  logic [LVL_W-1:0]  wm_level,
  output logic              wm_hit,
  output logic [LVL_W-1:0]  level_words,
  output logic [LVL_W-1:0]  peak_words,
  input  logic              peak_clear,
  output logic              overrun_sticky,
  output logic [15:0]       overrun_count,
  input  logic              overrun_clear
);

  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $fatal(1, "adc_stream_fifo_mc: DEPTH_WORDS must be a power of two >= 2");
  end
  if (DATA_W < 1 || N_CH < 1) begin : g_bad_width
    $fatal(1, "adc_stream_fifo_mc: DATA_W and N_CH must be >= 1");
  end

  logic [DATA_W+CH_W-1:0] mem [DEPTH_WORDS];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LVL_W-1:0]       count;
  logic [LVL_W-1:0]       next_count;
  logic [LVL_W-1:0]       peak;
  logic [15:0]            ovr_cnt;
  logic                   ovr_st;
  logic                   full;
  logic                   empty;
  logic                   ch_en;
  logic                   do_write;
  logic                   do_pop;
  logic                   discard;
  logic                   rd_adv;
  logic                   ovr_event;

  // Out-of-range tags never match a loop index, so they read as disabled.
  always_comb begin
    ch_en = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (push_ch == CH_W'(i)) ch_en = ch_enable[i];
    end
  end

  assign full  = (count == LVL_W'(DEPTH_WORDS));
  assign empty = (count == '0);

  assign push_ready = ~ch_en | drop_oldest | ~full;
  assign do_write   = push_valid & ch_en & (drop_oldest | ~full);
  assign do_pop     = pop_ready & ~empty;
  assign discard    = push_valid & ch_en & drop_oldest & full & ~pop_ready;
  assign rd_adv     = do_pop | discard;
  assign ovr_event  = ~flush & push_valid & ch_en & full & (~drop_oldest | ~pop_ready);

  // A drop-oldest discard is a write plus a read-pointer advance, so occupancy holds.
  always_comb begin
    next_count = count;
    if (flush) begin
      next_count = '0;
    end else begin
      case ({do_write, rd_adv})
        2'b10:   next_count = count + LVL_W'(1);
        2'b01:   next_count = count - LVL_W'(1);
        default: next_count = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !flush) mem[wr_ptr] <= {push_data, push_ch};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      peak    <= '0;
      ovr_st  <= 1'b0;
      ovr_cnt <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + AW'(1);
        if (rd_adv)   rd_ptr <= rd_ptr + AW'(1);
      end
      count <= next_count;

      if (peak_clear)             peak <= next_count;
      else if (next_count > peak) peak <= next_count;

      // An event coinciding with a clear restarts the count at one.
      if (ovr_event) begin
        ovr_st <= 1'b1;
        if (overrun_clear)           ovr_cnt <= 16'd1;
        else if (ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 16'd1;
      end else if (overrun_clear) begin
        ovr_st  <= 1'b0;
        ovr_cnt <= '0;
      end
    end
  end

  assign pop_valid      = ~empty;
  assign {pop_data, pop_ch} = mem[rd_ptr];
  assign level_words    = count;
  assign peak_words     = peak;
  assign wm_hit         = (wm_level != '0) && (count >= wm_level);
  assign overrun_sticky = ovr_st;
  assign overrun_count  = ovr_cnt;

endmodule

// File: tb/tb_adc_stream_fifo_mc.sv
// Bench for adc_stream_fifo_mc: a queue-based reference checked every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_adc_stream_fifo_mc;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int LVL_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic [CH_W-1:0]   push_ch;
  logic              push_ready;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic [CH_W-1:0]   pop_ch;
  logic              pop_ready;
  logic [N_CH-1:0]   ch_enable;
  logic              drop_oldest;
  logic              flush;
  logic [LVL_W-1:0]  wm_level;
  logic              wm_hit;
  logic [LVL_W-1:0]  level_words;
  logic [LVL_W-1:0]  peak_words;
  logic              peak_clear;
  logic              overrun_sticky;
  logic [15:0]       overrun_count;
  logic              overrun_clear;

  int n_tests = 0;
  int n_fail  = 0;

  adc_stream_fifo_mc #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH), .N_CH(N_CH)) dut (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_data(push_data),
    .push_ch(push_ch), .push_ready(push_ready), .pop_valid(pop_valid),
    .pop_data(pop_data), .pop_ch(pop_ch), .pop_ready(pop_ready),
    .ch_enable(ch_enable), .drop_oldest(drop_oldest), .flush(flush),
    .wm_level(wm_level), .wm_hit(wm_hit), .level_words(level_words),
    .peak_words(peak_words), .peak_clear(peak_clear),
    .overrun_sticky(overrun_sticky), .overrun_count(overrun_count),
    .overrun_clear(overrun_clear)
  );

  always #5 clk = ~clk;

  task automatic ck(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference state: queue of {data, ch}, peak, overrun sticky/count.
  logic [DATA_W+CH_W-1:0] q[$];
  int  m_peak   = 0;
  bit  m_sticky = 0;
  int  m_cnt    = 0;
  bit  chk_on   = 0;

  always @(negedge clk) begin
    bit en, full, exp_ready, popd, accept, ev;
    en        = (int'(push_ch) < N_CH) && ch_enable[push_ch];
    full      = (q.size() == DEPTH);
    exp_ready = !en || drop_oldest || !full;
    if (chk_on) begin
      ck("pop_valid", pop_valid, q.size() != 0);
      if (q.size() != 0) begin
        ck("pop_data", pop_data, q[0][DATA_W+CH_W-1:CH_W]);
        ck("pop_ch", pop_ch, q[0][CH_W-1:0]);
      end
      ck("level_words", level_words, q.size());
      ck("wm_hit", wm_hit, (wm_level != 0) && (q.size() >= int'(wm_level)));
      ck("peak_words", peak_words, m_peak);
      ck("push_ready", push_ready, exp_ready);
      ck("overrun_sticky", overrun_sticky, m_sticky);
      ck("overrun_count", overrun_count, m_cnt);
    end
    if (!rst_n) begin
      q.delete();
      m_peak = 0; m_sticky = 0; m_cnt = 0;
      chk_on = 1;
    end else begin
      ev = 0;
      if (flush) begin
        q.delete();
      end else begin
        popd   = pop_ready && q.size() != 0;
        accept = push_valid && en && (!full || drop_oldest);
        ev     = push_valid && en && full && (!drop_oldest || !pop_ready);
        if (popd || (accept && full)) void'(q.pop_front());
        if (accept) q.push_back({push_data, push_ch});
      end
      if (ev) begin
        m_sticky = 1;
        m_cnt = overrun_clear ? 1 : (m_cnt == 16'hFFFF ? m_cnt : m_cnt + 1);
      end else if (overrun_clear) begin
        m_sticky = 0; m_cnt = 0;
      end
      if (peak_clear) m_peak = q.size();
      else if (q.size() > m_peak) m_peak = q.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [CH_W-1:0] c);
    push_valid = 1; push_data = d; push_ch = c;
    step();
    push_valid = 0;
  endtask

  task automatic pulse_flush();
    flush = 1; step(); flush = 0;
  endtask

  task automatic pulse_oclr();
    overrun_clear = 1; step(); overrun_clear = 0;
  endtask

  initial begin
    rst_n = 0; push_valid = 0; push_data = '0; push_ch = '0; pop_ready = 0;
    ch_enable = '1; drop_oldest = 0; flush = 0; wm_level = 0; peak_clear = 0;
    overrun_clear = 0;
    step(); step();
    rst_n = 1;
    ck("reset_level", level_words, 0);
    ck("reset_push_ready", push_ready, 1);
    ck("reset_pop_valid", pop_valid, 0);

    // Ordering, tags, watermark
    wm_level = 6;
    for (int i = 0; i < 8; i++) push(32'h100 + i, CH_W'(i % 4));
    ck("fill_level", level_words, 8);
    ck("fill_peak", peak_words, 8);
    ck("fill_wm_hit", wm_hit, 1);
    for (int i = 0; i < 8; i++) begin
      pop_ready = 1;
      ck("order_data", pop_data, 32'h100 + i);
      ck("order_ch", pop_ch, i % 4);
      step();
    end
    pop_ready = 0;
    ck("drain_level", level_words, 0);
    ck("drain_wm_hit", wm_hit, 0);

    // Drop-new overflow
    for (int i = 0; i < 8; i++) push(32'h200 + i, 2'd0);
    push_valid = 1; push_data = 32'hAAA; push_ch = 2'd1;
    ck("dropnew_ready", push_ready, 0);
    step(); push_valid = 0;
    ck("dropnew_level", level_words, 8);
    ck("dropnew_sticky", overrun_sticky, 1);
    ck("dropnew_count", overrun_count, 1);
    ck("dropnew_head", pop_data, 32'h200);

    // Drop-oldest overflow
    pulse_flush(); pulse_oclr();
    drop_oldest = 1;
    for (int i = 0; i < 10; i++) push(i, 2'd3);
    ck("dropold_count", overrun_count, 2);
    for (int i = 0; i < 8; i++) begin
      pop_ready = 1;
      ck("dropold_data", pop_data, i + 2);
      step();
    end
    pop_ready = 0;
    for (int i = 0; i < 8; i++) push(32'h300 + i, 2'd0);
    pop_ready = 1; push(32'h3FF, 2'd0); pop_ready = 0;
    ck("dropold_pp_count", overrun_count, 2);
    ck("dropold_pp_level", level_words, 8);
    pulse_flush();
    drop_oldest = 0;

    // Channel mask
    pulse_oclr();
    ch_enable = 4'b1011;
    for (int i = 0; i < 4; i++) push(32'h400 + i, CH_W'(i));
    ck("mask_level", level_words, 3);
    ck("mask_sticky", overrun_sticky, 0);
    for (int i = 0; i < 3; i++) begin
      pop_ready = 1;
      ck("mask_data", pop_data, (i == 2) ? 32'h403 : 32'h400 + i);
      step();
    end
    pop_ready = 0;
    ch_enable = '1;

    // Clear coinciding with an event, flush during traffic, peak clear
    for (int i = 0; i < 10; i++) push(32'h500 + i, 2'd2);
    ck("pre_clr_count", overrun_count, 2);
    overrun_clear = 1; push(32'h5FF, 2'd2); overrun_clear = 0;
    ck("clr_evt_sticky", overrun_sticky, 1);
    ck("clr_evt_count", overrun_count, 1);
    push_valid = 1; pop_ready = 1; flush = 1;
    step();
    push_valid = 0; pop_ready = 0; flush = 0;
    ck("flush_level", level_words, 0);
    ck("flush_count", overrun_count, 1);
    ck("flush_peak", peak_words, 8);
    for (int i = 0; i < 3; i++) push(32'h600 + i, 2'd1);
    peak_clear = 1; step(); peak_clear = 0;
    ck("peak_clear", peak_words, 3);

    // Saturation
    for (int i = 0; i < 5; i++) push(32'h700 + i, 2'd0);
    push_valid = 1; push_data = 32'h777; push_ch = 2'd0;
    repeat (70000) step();
    push_valid = 0;
    ck("saturate", overrun_count, 16'hFFFF);

    // Reset mid-stream
    pulse_flush();
    for (int i = 0; i < 5; i++) push(32'h800 + i, 2'd1);
    ck("pre_rst_level", level_words, 5);
    rst_n = 0; step(); rst_n = 1;
    ck("rst_level", level_words, 0);
    ck("rst_pop_valid", pop_valid, 0);
    ck("rst_peak", peak_words, 0);
    ck("rst_count", overrun_count, 0);
    ck("rst_wm_hit", wm_hit, 0);
    push(32'hBEEF, 2'd1);
    ck("rst_push_valid", pop_valid, 1);
    ck("rst_push_data", pop_data, 32'hBEEF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      push_valid  = $urandom_range(0, 2) != 0;
      push_data   = $urandom;
      push_ch     = CH_W'($urandom_range(0, 3));
      pop_ready   = $urandom_range(0, 2) == 0;
      flush       = $urandom_range(0, 49) == 0;
      peak_clear  = !flush && $urandom_range(0, 29) == 0;
      overrun_clear = !flush && $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 99) == 0) drop_oldest = ~drop_oldest;
      if ($urandom_range(0, 49) == 0) ch_enable = N_CH'($urandom);
      if ($urandom_range(0, 19) == 0) wm_level = LVL_W'($urandom_range(0, 8));
      step();
    end
    push_valid = 0; pop_ready = 0; flush = 0; peak_clear = 0; overrun_clear = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_stream_fifo_mc.md
# adc_stream_fifo_mc

Parametrised, channel-tagged synchronous FIFO that buffers ADC sample words from the multi-channel sampler front end until firmware drains them over the Wishbone register block. It extends the single-stream ADC FIFO with:
- configurable data width and depth
- a per-word channel tag and a per-channel enable mask
- a selectable overflow policy (drop-new or drop-oldest)
- a saturating overrun counter
- a programmable watermark flag
- a resettable peak-level (high-water) tracker

## Interface
Parameters:
- DATA_W, 32, sample word width (>=1)
- DEPTH_WORDS, 64, FIFO depth; power of two, >=2 (elaboration-time $fatal otherwise)
- N_CH, 4, number of ADC channels (>=1)
- Derived: CH_W = max(1, clog2(N_CH)); LVL_W = clog2(DEPTH_WORDS+1); AW = clog2(DEPTH_WORDS)

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- push_valid  in  1  producer has a word
- push_data  in  DATA_W  sample word
- push_ch  in  CH_W  channel tag of push_data
- push_ready  out  1  push accepted when push_valid & push_ready
- pop_valid  out  1  FIFO non-empty
- pop_data  out  DATA_W  head word (first-word fall-through)
- pop_ch  out  CH_W  head word's channel tag
- pop_ready  in  1  consumer takes head
- ch_enable  in  N_CH  per-channel enable; words for disabled channels are discarded
- drop_oldest  in  1  0 = drop-new policy, 1 = drop-oldest policy
- flush  in  1  synchronous FIFO empty command
- wm_level  in  LVL_W  watermark threshold; 0 disables the flag
- wm_hit  out  1  level_words >= wm_level and wm_level != 0
- level_words  out  LVL_W  current occupancy 0..DEPTH_WORDS
- peak_words  out  LVL_W  max occupancy since reset/peak_clear
- peak_clear  in  1  reset peak_words to current level
- overrun_sticky  out  1  set on any overrun event
- overrun_count  out  16  saturating count of overrun events
- overrun_clear  in  1  clears sticky and count (driven by W1C register)

## Operation
- Storage: DATA_W+CH_W wide x DEPTH_WORDS array, not reset. Pointers wrap naturally modulo DEPTH_WORDS. count is an explicit LVL_W register.
- full = (count == DEPTH_WORDS); empty = (count == 0); pop_valid = ~empty.
- Disabled channel (ch_enable[push_ch]==0): push_ready=1, word discarded, no count or overrun effect. push_ch >= N_CH is treated as disabled.
- Drop-new (drop_oldest=0):
  - push_ready = ~full.
  - push to full FIFO is rejected, even with a simultaneous pop; this counts as an overrun event.
- Drop-oldest (drop_oldest=1):
  - push_ready = 1.
  - Push while full and no pop: word written at wr_ptr; rd_ptr advances (oldest discarded); count unchanged; overrun event.
  - Push while full with pop: normal push+pop; no event.
- Normal push/pop: count +1 on push only, -1 on pop only, unchanged on both.
- Overrun event:
  - overrun_sticky <= 1.
  - overrun_count <= overrun_count+1, saturating at 0xFFFF.
  - If overrun_clear and an event coincide, the event wins: sticky=1, count=1.
- flush (highest priority after reset):
  - pointers and count <= 0.
  - A push or pop in the same cycle is ignored and does not raise an overrun event.
  - Sticky, count and peak are unchanged.
- Peak tracking:
  - Each cycle, peak_words <= max(peak_words, next_count).
  - peak_clear loads next_count.
- drop_oldest, ch_enable and wm_level may change any cycle; they take effect combinationally on that cycle's handshake.

## Timing
- Reset (rst_n=0 at edge): count, pointers, peak_words, overrun_sticky and overrun_count all 0. Resulting outputs:
  - pop_valid=0, wm_hit=0, level_words=0
  - push_ready=1
  - pop_data/pop_ch are don't-care while pop_valid=0
- Reset mid-operation discards all contents; the next cycle behaves as empty.
- Push accepted at edge N: pop_valid=1 and pop_data valid after edge N. Latency is 1 cycle; there is no combinational push→pop path.
- pop_data/pop_ch are a combinational read of mem[rd_ptr]. They change only after the edge at which a pop (or drop-oldest discard) occurs.
- level_words, wm_hit, peak_words and overrun outputs depend only on registered state. They update 1 cycle after the causing edge.
- push_ready depends combinationally on full, drop_oldest, ch_enable and push_ch.

## Test plan
- Ordering/tags, DEPTH_WORDS=8, N_CH=4:
  - Stimulus: push 8 words (data 0x100+i, ch i%4); then pop all.
  - Response: identical order and tags; level 8→0; peak_words=8; wm_level=6 gives wm_hit exactly while level >= 6.
- Drop-new overflow:
  - Stimulus: fill 8; push 0xAAA with pop_ready=0.
  - Response: push_ready=0, level stays 8, overrun_sticky=1, overrun_count=1, head unchanged.
- Drop-oldest overflow:
  - Stimulus: fill with 0..7; push 0x8 and 0x9 while full.
  - Response: pops yield 2..9, overrun_count=2.
  - Follow-up: push+pop same cycle while full gives no increment.
- Channel mask:
  - Stimulus: ch_enable=4'b1011; push 4 words on ch 0..3.
  - Response: level=3, ch2 word absent, no overrun.
- Simultaneous events:
  - overrun_clear during an overrun event → sticky=1, count=1.
  - flush during push/pop → level=0, overrun unchanged.
  - peak_clear → peak equals current level.
  - Drive 70000 overrun events → count saturates at 0xFFFF.
- Reset mid-stream:
  - Stimulus: rst_n low for 1 cycle at level 5.
  - Response: all outputs at reset values next cycle; a new push appears at pop_data 1 cycle later.
